ahb3lite_interconnect_qos_slave_port: RTL and testbench

AHB3LITE_INTERCONNECT_QOS_SLAVE_PORT -- requirements
Module: ahb3lite_interconnect_qos_slave_port

---
 rtl/ahb3lite_interconnect_qos_slave_port.sv | 172 +++++++++++++++++
 tb/tb_ahb3lite_interconnect_qos_slave_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_qos_slave_port.sv
// AHB3-Lite interconnect slave port with QoS arbitration:
// priority round-robin, starvation promotion, burst and lock hold.
module ahb3lite_interconnect_qos_slave_port #(
    parameter  int HADDR_SIZE   = 32,
    parameter  int HDATA_SIZE   = 32,
    parameter  int MASTERS      = 4,
    parameter  int STARVE_LIMIT = 16,
    localparam int MASTER_BITS  = (MASTERS == 1) ? 1 : $clog2(MASTERS)
) (
    input  logic                                HCLK,
    input  logic                                HRESET,
    input  logic [MASTERS-1:0][MASTER_BITS-1:0] mstpriority,
    input  logic [MASTERS-1:0]                  mstHSEL,
    input  logic [MASTERS-1:0][HADDR_SIZE-1:0]  mstHADDR,
    input  logic [MASTERS-1:0][HDATA_SIZE-1:0]  mstHWDATA,
    input  logic [MASTERS-1:0]                  mstHWRITE,
    input  logic [MASTERS-1:0][2:0]             mstHSIZE,
    input  logic [MASTERS-1:0][2:0]             mstHBURST,
    input  logic [MASTERS-1:0][3:0]             mstHPROT,
    input  logic [MASTERS-1:0][1:0]             mstHTRANS,
    input  logic [MASTERS-1:0]                  mstHMASTLOCK,
    input  logic [MASTERS-1:0]                  mstHREADY,
    output logic [HDATA_SIZE-1:0]               mstHRDATA,
    output logic                                mstHREADYOUT,
    output logic                                mstHRESP,
    output logic                                slv_HSEL,
    output logic [HADDR_SIZE-1:0]               slv_HADDR,
    output logic [HDATA_SIZE-1:0]               slv_HWDATA,
    output logic                                slv_HWRITE,
    output logic [2:0]                          slv_HSIZE,
    output logic [2:0]                          slv_HBURST,
    output logic [3:0]                          slv_HPROT,
    output logic [1:0]                          slv_HTRANS,
    output logic                                slv_HMASTLOCK,
    output logic                                slv_HREADYOUT,
    input  logic [HDATA_SIZE-1:0]               slv_HRDATA,
    input  logic                                slv_HREADY,
    input  logic                                slv_HRESP,
    output logic [MASTERS-1:0]                  granted_master,
    output logic [MASTERS-1:0]                  starved
);

    localparam int LEVELS = 1 << MASTER_BITS;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10, SEQ = 2'b11;

    logic [MASTER_BITS-1:0] g_q, g_d, g_dly_q, sel, maxp;
    logic [MASTER_BITS-1:0] last_q [LEVELS];
    logic [SW-1:0]          cnt_q [MASTERS];
    logic [3:0]             burst_q, burst_d;
    logic                   first_q, first_d;
    logic                   lock_hold, switch_ok, upd, change;
    logic                   rr_hit, st_hit;
    logic [1:0]             htrans_raw, htrans_eff;

    function automatic logic [3:0] burst_len(input logic [2:0] hb);
        unique case (hb)
            3'b010, 3'b011: burst_len = 4'd3;
            3'b100, 3'b101: burst_len = 4'd7;
            3'b110, 3'b111: burst_len = 4'd15;
            default:        burst_len = 4'd0;
        endcase
    endfunction

    always_comb begin
        for (int m = 0; m < MASTERS; m++) begin
            granted_master[m] = (g_q == MASTER_BITS'(m));
            starved[m] = (STARVE_LIMIT != 0) && (cnt_q[m] == SLIM);
        end
    end

    // Starved requesters first, else round-robin within the top level.
    always_comb begin
        int idx;
        st_hit = 1'b0;
        rr_hit = 1'b0;
        sel    = g_q;
        maxp   = '0;
        idx    = 0;
        for (int m = 0; m < MASTERS; m++)
            if (mstHSEL[m] && mstpriority[m] > maxp)
                maxp = mstpriority[m];
        for (int k = 1; k <= MASTERS; k++) begin
            idx = (int'(last_q[maxp]) + k) % MASTERS;
            if (!rr_hit && mstHSEL[idx] && mstpriority[idx] == maxp) begin
                rr_hit = 1'b1;
                sel    = MASTER_BITS'(idx);
            end
        end
        for (int m = MASTERS - 1; m >= 0; m--)
            if (starved[m] && mstHSEL[m]) begin
                st_hit = 1'b1;
                sel    = MASTER_BITS'(m);
            end
    end

    assign lock_hold = mstHMASTLOCK[g_q] && (mstHTRANS[g_q] != IDLE);
    assign switch_ok = !lock_hold && (burst_q == 4'd0 || !mstHSEL[g_q]);
    assign upd       = slv_HREADY && switch_ok;
    assign g_d       = upd ? sel : g_q;
    assign change    = upd && (sel != g_q);

    always_comb begin
        htrans_raw = mstHTRANS[g_q];
        htrans_eff = htrans_raw;
        if (htrans_raw == BUSY)
            htrans_eff = IDLE;
        else if (htrans_raw == SEQ && first_q)
            htrans_eff = NONSEQ;
    end

    always_comb begin
        burst_d = burst_q;
        first_d = first_q;
        if (change) begin
            burst_d = 4'd0;
            first_d = 1'b1;
        end else begin
            if (slv_HRESP)
                burst_d = 4'd0;
            else if (slv_HREADY)
                unique case (htrans_eff)
                    IDLE:    burst_d = 4'd0;
                    NONSEQ:  burst_d = burst_len(mstHBURST[g_q]);
                    SEQ:     burst_d = (burst_q == 4'd0) ? 4'd0 : burst_q - 4'd1;
                    default: burst_d = burst_q;
                endcase
            if (slv_HREADY && htrans_eff != IDLE)
                first_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            g_q     <= '0;
            g_dly_q <= '0;
            burst_q <= 4'd0;
            first_q <= 1'b0;
            for (int l = 0; l < LEVELS; l++) last_q[l] <= '0;
            for (int m = 0; m < MASTERS; m++) cnt_q[m] <= '0;
        end else begin
            g_q     <= g_d;
            burst_q <= burst_d;
            first_q <= first_d;
            if (slv_HREADY) g_dly_q <= g_q;
            if (upd && rr_hit && !st_hit) last_q[maxp] <= sel;
            for (int m = 0; m < MASTERS; m++) begin
                if (!mstHSEL[m] || g_d == MASTER_BITS'(m))
                    cnt_q[m] <= '0;
                else if (slv_HREADY && cnt_q[m] != SLIM)
                    cnt_q[m] <= cnt_q[m] + 1'b1;
            end
        end
    end

    assign slv_HSEL      = mstHSEL[g_q];
    assign slv_HADDR     = mstHADDR[g_q];
    assign slv_HWDATA    = mstHWDATA[g_dly_q];
    assign slv_HWRITE    = mstHWRITE[g_q];
    assign slv_HSIZE     = mstHSIZE[g_q];
    assign slv_HBURST    = mstHBURST[g_q];
    assign slv_HPROT     = mstHPROT[g_q];
    assign slv_HTRANS    = htrans_eff;
    assign slv_HMASTLOCK = mstHMASTLOCK[g_q];
    assign slv_HREADYOUT = mstHREADY[g_q];
    assign mstHRDATA     = slv_HRDATA;
    assign mstHREADYOUT  = slv_HREADY;
    assign mstHRESP      = slv_HRESP;

endmodule

// File: tb/tb_ahb3lite_interconnect_qos_slave_port.sv
// Directed bench for the QoS slave port: arbitration table plus
// burst, lock, first-beat, error and reset sequences.
module tb_ahb3lite_interconnect_qos_slave_port;

    localparam int M  = 4;
    localparam int MB = 2;
    localparam logic [31:0] ADDR0 = 32'hA000_0000;
    localparam logic [31:0] DATA0 = 32'hD000_0000;
    localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01;
    localparam logic [1:0] NS = 2'b10, SEQ = 2'b11;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic [M-1:0][MB-1:0] mstpriority;
    logic [M-1:0]      mstHSEL;
    logic [M-1:0][31:0] mstHADDR;
    logic [M-1:0][31:0] mstHWDATA;
    logic [M-1:0]      mstHWRITE;
    logic [M-1:0][2:0] mstHSIZE;
    logic [M-1:0][2:0] mstHBURST;
    logic [M-1:0][3:0] mstHPROT;
    logic [M-1:0][1:0] mstHTRANS;
    logic [M-1:0]      mstHMASTLOCK;
    logic [M-1:0]      mstHREADY;
    logic [31:0]       mstHRDATA;
    logic              mstHREADYOUT, mstHRESP;
    logic              slv_HSEL;
    logic [31:0]       slv_HADDR, slv_HWDATA;
    logic              slv_HWRITE;
    logic [2:0]        slv_HSIZE, slv_HBURST;
    logic [3:0]        slv_HPROT;
    logic [1:0]        slv_HTRANS;
    logic              slv_HMASTLOCK, slv_HREADYOUT;
    logic [31:0]       slv_HRDATA;
    logic              slv_HREADY, slv_HRESP;
    logic [M-1:0]      granted_master, starved;

    int n_chk = 0;
    int n_fail = 0;

    ahb3lite_interconnect_qos_slave_port #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .MASTERS(M), .STARVE_LIMIT(4)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .mstpriority(mstpriority),
        .mstHSEL(mstHSEL), .mstHADDR(mstHADDR), .mstHWDATA(mstHWDATA),
        .mstHWRITE(mstHWRITE), .mstHSIZE(mstHSIZE), .mstHBURST(mstHBURST),
        .mstHPROT(mstHPROT), .mstHTRANS(mstHTRANS),
        .mstHMASTLOCK(mstHMASTLOCK), .mstHREADY(mstHREADY),
        .mstHRDATA(mstHRDATA), .mstHREADYOUT(mstHREADYOUT),
        .mstHRESP(mstHRESP), .slv_HSEL(slv_HSEL), .slv_HADDR(slv_HADDR),
        .slv_HWDATA(slv_HWDATA), .slv_HWRITE(slv_HWRITE),
        .slv_HSIZE(slv_HSIZE), .slv_HBURST(slv_HBURST),
        .slv_HPROT(slv_HPROT), .slv_HTRANS(slv_HTRANS),
        .slv_HMASTLOCK(slv_HMASTLOCK), .slv_HREADYOUT(slv_HREADYOUT),
        .slv_HRDATA(slv_HRDATA), .slv_HREADY(slv_HREADY),
        .slv_HRESP(slv_HRESP), .granted_master(granted_master),
        .starved(starved)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [3:0] hsel;
        logic [7:0] prio;
        logic       rdy;
        logic [3:0] egnt;
        logic [3:0] estv;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_all();
        mstHSEL      = '0;
        mstpriority  = '0;
        mstHTRANS    = '0;
        mstHBURST    = '0;
        mstHMASTLOCK = '0;
        mstHWRITE    = '0;
        mstHSIZE     = '0;
        mstHPROT     = '0;
        mstHREADY    = 4'b1011;
        slv_HREADY   = 1'b1;
        slv_HRESP    = 1'b0;
        slv_HRDATA   = '0;
    endtask

    task automatic do_reset();
        idle_all();
        HRESET = 1'b1;
        clk1();
        clk1();
        HRESET = 1'b0;
    endtask

    function automatic int oh2i(input logic [3:0] oh);
        oh2i = 0;
        for (int i = 0; i < 4; i++) if (oh[i]) oh2i = i;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gcur;
        int gdly;
        for (int m = 0; m < M; m++) begin
            mstHADDR[m]  = ADDR0 + 32'(m);
            mstHWDATA[m] = DATA0 + 32'(m);
        end

        // grant / starved flags expected after each edge
        tbl[0]  = '{4'b1111, 8'h00, 1'b1, 4'b0010, 4'b0000};
        tbl[1]  = '{4'b1111, 8'h00, 1'b1, 4'b0100, 4'b0000};
        tbl[2]  = '{4'b1111, 8'h00, 1'b1, 4'b1000, 4'b0000};
        tbl[3]  = '{4'b1111, 8'h00, 1'b1, 4'b0001, 4'b0000};
        tbl[4]  = '{4'b1111, 8'h00, 1'b0, 4'b0001, 4'b0000};
        tbl[5]  = '{4'b1111, 8'h20, 1'b1, 4'b0100, 4'b0010};
        tbl[6]  = '{4'b1111, 8'h20, 1'b1, 4'b0010, 4'b0000};
        tbl[7]  = '{4'b1111, 8'h20, 1'b1, 4'b0100, 4'b1000};
        tbl[8]  = '{4'b0111, 8'h20, 1'b1, 4'b0100, 4'b0001};
        tbl[9]  = '{4'b0011, 8'h20, 1'b1, 4'b0001, 4'b0000};
        tbl[10] = '{4'b0000, 8'h20, 1'b1, 4'b0001, 4'b0000};
        tbl[11] = '{4'b0010, 8'h20, 1'b1, 4'b0010, 4'b0000};

        do_reset();
        chk("rst_grant", granted_master, 4'b0001);
        chk("rst_starved", starved, 4'b0000);
        chk("rst_haddr", slv_HADDR, ADDR0);
        chk("rst_hwdata", slv_HWDATA, DATA0);
        chk("rst_hreadyout", slv_HREADYOUT, 1'b1);

        for (int m = 0; m < M; m++) mstHTRANS[m] = NS;
        gcur = 0;
        gdly = 0;
        for (int i = 0; i < 12; i++) begin
            mstHSEL     = tbl[i].hsel;
            mstpriority = tbl[i].prio;
            slv_HREADY  = tbl[i].rdy;
            clk1();
            if (tbl[i].rdy) gdly = gcur;
            gcur = oh2i(tbl[i].egnt);
            chk($sformatf("tbl_grant[%0d]", i), granted_master, tbl[i].egnt);
            chk($sformatf("tbl_starved[%0d]", i), starved, tbl[i].estv);
            chk($sformatf("tbl_haddr[%0d]", i), slv_HADDR, ADDR0 + 32'(gcur));
            chk($sformatf("tbl_hwdata[%0d]", i), slv_HWDATA, DATA0 + 32'(gdly));
        end

        // starvation promotion of a low-priority requester
        do_reset();
        mstpriority[0] = 2'd3;
        mstHSEL = 4'b0011;
        mstHTRANS[0] = NS;
        mstHTRANS[1] = NS;
        for (int e = 1; e <= 3; e++) begin
            clk1();
            chk($sformatf("stv_wait[%0d]", e), starved, 4'b0000);
            chk($sformatf("stv_gnt[%0d]", e), granted_master, 4'b0001);
        end
        clk1();
        chk("stv_flag", starved, 4'b0010);
        chk("stv_flag_gnt", granted_master, 4'b0001);
        clk1();
        chk("stv_grant", granted_master, 4'b0010);
        chk("stv_clear", starved, 4'b0000);
        clk1();
        chk("stv_back", granted_master, 4'b0001);

        // INCR4 held against a higher-priority request, with a wait state
        do_reset();
        mstHSEL = 4'b0001;
        mstHBURST[0] = 3'b011;
        mstHTRANS[0] = NS;
        #1;
        chk("bst_nonseq", slv_HTRANS, NS);
        clk1();
        mstHTRANS[0] = SEQ;
        mstHSEL[1] = 1'b1;
        mstpriority[1] = 2'd1;
        mstHTRANS[1] = NS;
        #1;
        chk("bst_seq", slv_HTRANS, SEQ);
        clk1();
        chk("bst_beat2", granted_master, 4'b0001);
        slv_HREADY = 1'b0;
        clk1();
        chk("bst_wait", granted_master, 4'b0001);
        slv_HREADY = 1'b1;
        clk1();
        chk("bst_beat3", granted_master, 4'b0001);
        clk1();
        chk("bst_beat4", granted_master, 4'b0001);
        mstHTRANS[0] = IDLE;
        clk1();
        chk("bst_switch", granted_master, 4'b0010);

        // locked master holds the bus against a starved requester
        do_reset();
        mstHSEL = 4'b0100;
        mstHTRANS[2] = NS;
        mstHMASTLOCK[2] = 1'b1;
        clk1();
        chk("lck_grant", granted_master, 4'b0100);
        mstHSEL[0] = 1'b1;
        mstHTRANS[0] = NS;
        for (int e = 2; e <= 5; e++) begin
            clk1();
            chk($sformatf("lck_held[%0d]", e), granted_master, 4'b0100);
        end
        chk("lck_starved", starved, 4'b0001);
        chk("lck_hreadyout", slv_HREADYOUT, 1'b0);
        chk("lck_mastlock", slv_HMASTLOCK, 1'b1);
        clk1();
        chk("lck_hold", granted_master, 4'b0100);
        mstHTRANS[2] = IDLE;
        mstHMASTLOCK[2] = 1'b0;
        clk1();
        chk("lck_release", granted_master, 4'b0001);
        chk("lck_stv_clear", starved, 4'b0000);

        // new grant presenting SEQ, write data lag, BUSY masking
        do_reset();
        mstHSEL = 4'b0010;
        mstHTRANS[1] = SEQ;
        mstHBURST[1] = 3'b001;
        clk1();
        chk("fb_grant", granted_master, 4'b0010);
        chk("fb_nonseq", slv_HTRANS, NS);
        chk("fb_wdata_old", slv_HWDATA, DATA0);
        clk1();
        chk("fb_seq", slv_HTRANS, SEQ);
        chk("fb_wdata_new", slv_HWDATA, DATA0 + 32'd1);
        mstHTRANS[1] = BUSY;
        #1;
        chk("busy_idle", slv_HTRANS, IDLE);

        // error response mid INCR8 frees the bus
        do_reset();
        mstHSEL = 4'b0001;
        mstHBURST[0] = 3'b101;
        mstHTRANS[0] = NS;
        clk1();
        mstHTRANS[0] = SEQ;
        mstHSEL[3] = 1'b1;
        mstpriority[3] = 2'd2;
        mstHTRANS[3] = NS;
        clk1();
        clk1();
        chk("err_hold", granted_master, 4'b0001);
        slv_HRESP = 1'b1;
        slv_HREADY = 1'b0;
        slv_HRDATA = 32'h5A5A_1234;
        #1;
        chk("err_hresp", mstHRESP, 1'b1);
        chk("err_hreadyout", mstHREADYOUT, 1'b0);
        chk("err_hrdata", mstHRDATA, 32'h5A5A_1234);
        clk1();
        chk("err_wait", granted_master, 4'b0001);
        slv_HREADY = 1'b1;
        clk1();
        chk("err_switch", granted_master, 4'b1000);

        // reset in the middle of a burst leaves no hold behind
        do_reset();
        mstHSEL = 4'b0001;
        mstHBURST[0] = 3'b101;
        mstHTRANS[0] = NS;
        clk1();
        mstHTRANS[0] = SEQ;
        clk1();
        HRESET = 1'b1;
        clk1();
        HRESET = 1'b0;
        chk("rstb_grant", granted_master, 4'b0001);
        mstHSEL[3] = 1'b1;
        mstpriority[3] = 2'd2;
        mstHTRANS[3] = NS;
        clk1();
        chk("rstb_switch", granted_master, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
